// File: rtl/rv32i_defs.sv
// Shared definitions for the instruction-memory loader: FSM states and error codes.
package rv32i_defs;

    typedef enum logic [2:0] {
        LD_IDLE,
        LD_HDR_HI,
        LD_HDR_LO,
        LD_PAYLOAD,
        LD_CSUM,
        LD_DONE,
        LD_ERR
    } loader_state_e;

    typedef enum logic [1:0] {
        ERR_NONE    = 2'd0,
        ERR_LEN     = 2'd1,
        ERR_CSUM    = 2'd2,
        ERR_TIMEOUT = 2'd3
    } load_err_e;

    // States in which the loader is consuming stream bytes.
    function automatic logic is_stream_state(input loader_state_e s);
        return (s == LD_HDR_HI) || (s == LD_HDR_LO) || (s == LD_PAYLOAD) || (s == LD_CSUM);
    endfunction

endpackage

// File: rtl/imem_timeout.sv
// Idle-cycle watchdog: counts cycles without an accepted byte while enabled.
module imem_timeout #(
    parameter int TIMEOUT_CYCLES = 65535,
    localparam int CW = $clog2(TIMEOUT_CYCLES + 1)
) (
    input  logic clk,
    input  logic rst_n,
    input  logic en_i,
    input  logic acc_i,
    output logic expired_o
);

    logic [CW-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (!en_i || acc_i) begin
            cnt_d = '0;
        end else if (cnt_q != CW'(TIMEOUT_CYCLES)) begin
            cnt_d = cnt_q + CW'(1);
        end
    end

    // Fires on the cycle whose increment would reach the limit, so the FSM leaves on that edge.
    assign expired_o = en_i && !acc_i && (cnt_q == CW'(TIMEOUT_CYCLES - 1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/imem_loader.sv
// Boot loader: receives a length-prefixed, XOR-checksummed byte stream and writes it
// into instruction memory, holding the core until a load completes cleanly.
module imem_loader
    import rv32i_defs::*;
#(
    parameter int NUM_INSTR      = 32,
    parameter int TIMEOUT_CYCLES = 65535,
    localparam int NB = 4 * NUM_INSTR,
    localparam int AW = $clog2(NB)
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          start_i,
    input  logic          byte_valid_i,
    input  logic [7:0]    byte_data_i,
    output logic          byte_ready_o,
    output logic          mem_we_o,
    output logic [AW-1:0] mem_waddr_o,
    output logic [7:0]    mem_wdata_o,
    output logic          core_hold_o,
    output logic          load_done_o,
    output logic [1:0]    err_code_o
);

    loader_state_e state_q, state_d;
    load_err_e     err_q, err_d;
    logic [AW-1:0] cnt_q, cnt_d;
    logic [AW-1:0] last_q, last_d;
    logic [AW-1:0] waddr_q, waddr_d;
    logic [7:0]    hdr_hi_q, hdr_hi_d;
    logic [7:0]    csum_q, csum_d;
    logic [7:0]    wdata_q, wdata_d;
    logic          ready_q, ready_d;
    logic          we_q, we_d;
    logic          hold_q, hold_d;
    logic          done_q, done_d;

    logic          accept;
    logic          expired;
    logic          timing_en;
    logic [15:0]   n_word;

    assign accept    = byte_valid_i && ready_q;
    assign timing_en = (state_q == LD_HDR_LO) || (state_q == LD_PAYLOAD) || (state_q == LD_CSUM);
    assign n_word    = {hdr_hi_q, byte_data_i};

    imem_timeout #(
        .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
    ) u_timeout (
        .clk      (clk),
        .rst_n    (rst_n),
        .en_i     (timing_en),
        .acc_i    (accept),
        .expired_o(expired)
    );

    always_comb begin
        state_d  = state_q;
        err_d    = err_q;
        cnt_d    = cnt_q;
        last_d   = last_q;
        hdr_hi_d = hdr_hi_q;
        csum_d   = csum_q;
        waddr_d  = waddr_q;
        wdata_d  = wdata_q;
        we_d     = 1'b0;

        case (state_q)
            LD_IDLE, LD_DONE, LD_ERR: begin
                if (start_i) begin
                    state_d = LD_HDR_HI;
                    err_d   = ERR_NONE;
                    csum_d  = '0;
                    cnt_d   = '0;
                end
            end
            LD_HDR_HI: begin
                if (accept) begin
                    hdr_hi_d = byte_data_i;
                    state_d  = LD_HDR_LO;
                end
            end
            LD_HDR_LO: begin
                if (accept) begin
                    if ((n_word != 16'd0) && (int'(n_word) <= NUM_INSTR)) begin
                        last_d  = AW'({n_word, 2'b00} - 18'd1);
                        cnt_d   = '0;
                        state_d = LD_PAYLOAD;
                    end else begin
                        err_d   = ERR_LEN;
                        state_d = LD_ERR;
                    end
                end else if (expired) begin
                    err_d   = ERR_TIMEOUT;
                    state_d = LD_ERR;
                end
            end
            LD_PAYLOAD: begin
                if (accept) begin
                    we_d    = 1'b1;
                    waddr_d = cnt_q;
                    wdata_d = byte_data_i;
                    csum_d  = csum_q ^ byte_data_i;
                    // Counter parks on the last index instead of wrapping.
                    if (cnt_q == last_q) begin
                        state_d = LD_CSUM;
                    end else begin
                        cnt_d = cnt_q + AW'(1);
                    end
                end else if (expired) begin
                    err_d   = ERR_TIMEOUT;
                    state_d = LD_ERR;
                end
            end
            LD_CSUM: begin
                if (accept) begin
                    if (byte_data_i == csum_q) begin
                        state_d = LD_DONE;
                    end else begin
                        err_d   = ERR_CSUM;
                        state_d = LD_ERR;
                    end
                end else if (expired) begin
                    err_d   = ERR_TIMEOUT;
                    state_d = LD_ERR;
                end
            end
            default: state_d = LD_IDLE;
        endcase

        ready_d = is_stream_state(state_d);
        hold_d  = (state_d != LD_DONE);
        done_d  = (state_d == LD_DONE);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= LD_IDLE;
            err_q    <= ERR_NONE;
            cnt_q    <= '0;
            last_q   <= '0;
            hdr_hi_q <= '0;
            csum_q   <= '0;
            waddr_q  <= '0;
            wdata_q  <= '0;
            we_q     <= 1'b0;
            ready_q  <= 1'b0;
            hold_q   <= 1'b1;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            err_q    <= err_d;
            cnt_q    <= cnt_d;
            last_q   <= last_d;
            hdr_hi_q <= hdr_hi_d;
            csum_q   <= csum_d;
            waddr_q  <= waddr_d;
            wdata_q  <= wdata_d;
            we_q     <= we_d;
            ready_q  <= ready_d;
            hold_q   <= hold_d;
            done_q   <= done_d;
        end
    end

    assign byte_ready_o = ready_q;
    assign mem_we_o     = we_q;
    assign mem_waddr_o  = waddr_q;
    assign mem_wdata_o  = wdata_q;
    assign core_hold_o  = hold_q;
    assign load_done_o  = done_q;
    assign err_code_o   = err_q;

endmodule
